// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the instruction-buffer entry record.
package cpu_pkg;
  localparam int ADDR_WIDTH_DEF = 64;
  localparam int INST_WIDTH_DEF = 32;
  localparam int PC_INCR        = 4;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] pc;
    logic [INST_WIDTH_DEF-1:0] inst;
  } ibuf_entry_t;
endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/decode side bundle of the instruction buffer; master is the fetch/decode pair, slave is the buffer.
interface inst_buffer_if #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH_DEF,
  parameter int INST_WIDTH = cpu_pkg::INST_WIDTH_DEF,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_pc;
  logic [INST_WIDTH-1:0] wr_inst;
  logic                  wr_ready;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_pc;
  logic [ADDR_WIDTH-1:0] rd_pc4;
  logic [INST_WIDTH-1:0] rd_inst;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;

  modport master (
    output flush, wr_valid, wr_pc, wr_inst, rd_ready,
    input  wr_ready, rd_valid, rd_pc, rd_pc4, rd_inst, count, empty, full
  );
  modport slave (
    input  flush, wr_valid, wr_pc, wr_inst, rd_ready,
    output wr_ready, rd_valid, rd_pc, rd_pc4, rd_inst, count, empty, full
  );
endinterface

// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction FIFO with redirect flush.
// INST_BUFFER_BYPASS_EN adds a same-cycle wr->rd path when the buffer is empty.
module inst_buffer
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int INST_WIDTH = INST_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic           clk,
  input  logic           reset,
  inst_buffer_if.slave   bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_d   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_d [DEPTH];

  logic [PW-1:0]         count;
  logic                  empty, full, byp, rd_valid, do_push, do_pop;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic [ADDR_WIDTH-1:0] rd_pc;

  // Extra pointer MSB makes the difference a true occupancy count.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign empty  = (count == '0);
  assign full   = (count == PW'(DEPTH));
  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];

`ifdef INST_BUFFER_BYPASS_EN
  assign byp      = empty && bus.wr_valid && !bus.flush;
  assign rd_valid = (!empty || byp) && !bus.flush;
`else
  assign byp      = 1'b0;
  assign rd_valid = !empty;
`endif

  // A bypassed word that decode takes right away never occupies a slot.
  assign do_pop  = !empty && bus.rd_ready;
  assign do_push = bus.wr_valid && !full && !(byp && bus.rd_ready);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        pc_mem_d[wr_idx]   = bus.wr_pc;
        inst_mem_d[wr_idx] = bus.wr_inst;
        wr_ptr_d           = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

  assign rd_pc        = byp ? bus.wr_pc : pc_mem_q[rd_idx];
  assign bus.rd_pc    = rd_pc;
  assign bus.rd_pc4   = rd_pc + ADDR_WIDTH'(PC_INCR);
  assign bus.rd_inst  = byp ? bus.wr_inst : inst_mem_q[rd_idx];
  assign bus.rd_valid = rd_valid;
  assign bus.wr_ready = !full;
  assign bus.count    = count;
  assign bus.empty    = empty;
  assign bus.full     = full;
endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: directed table, corner sequences and a randomized queue-model run.
module tb_inst_buffer;
  import cpu_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

  inst_buffer_if #(.ADDR_WIDTH(64), .INST_WIDTH(32), .DEPTH(DEPTH)) bus ();
  inst_buffer #(.ADDR_WIDTH(64), .INST_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic        rr;
    logic [63:0] pc;
    int          cnt;
    logic [63:0] head;
  } vec_t;

  function automatic logic [31:0] inst_of(logic [63:0] pc);
    return pc[31:0] ^ 32'hA5A5_1234;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(logic f, logic wv, logic rr, logic [63:0] pc);
    bus.flush    = f;
    bus.wr_valid = wv;
    bus.rd_ready = rr;
    bus.wr_pc    = pc;
    bus.wr_inst  = inst_of(pc);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_state(string nm, int cnt);
    chk({nm, ".count"}, 64'(bus.count), 64'(cnt));
    chk({nm, ".empty"}, 64'(bus.empty), 64'(cnt == 0));
    chk({nm, ".full"},  64'(bus.full),  64'(cnt == DEPTH));
  endtask

  vec_t        tbl[10];
  ibuf_entry_t q[$];
  ibuf_entry_t e;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 64'h0,  1, 64'h0};
    tbl[1] = '{1'b1, 1'b0, 64'h4,  2, 64'h0};
    tbl[2] = '{1'b1, 1'b0, 64'h8,  3, 64'h0};
    tbl[3] = '{1'b1, 1'b0, 64'hC,  4, 64'h0};
    tbl[4] = '{1'b1, 1'b0, 64'h10, 4, 64'h0};
    tbl[5] = '{1'b0, 1'b1, 64'h0,  3, 64'h4};
    tbl[6] = '{1'b0, 1'b1, 64'h0,  2, 64'h8};
    tbl[7] = '{1'b0, 1'b1, 64'h0,  1, 64'hC};
    tbl[8] = '{1'b0, 1'b1, 64'h0,  0, 64'h0};
    tbl[9] = '{1'b0, 1'b1, 64'h0,  0, 64'h0};

    // Reset
    reset = 1'b0;
    drive(0, 0, 0, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_state("reset", 0);
    chk("reset.rd_valid", 64'(bus.rd_valid), 64'h0);
    chk("reset.wr_ready", 64'(bus.wr_ready), 64'h1);
    chk("reset.rd_pc",    bus.rd_pc,   64'h0);
    chk("reset.rd_inst",  64'(bus.rd_inst), 64'h0);
    chk("reset.rd_pc4",   bus.rd_pc4,  64'h4);

    // Fill, overflow attempt, drain, underflow attempt
    for (int i = 0; i < 10; i++) begin
      drive(0, tbl[i].wv, tbl[i].rr, tbl[i].pc);
      step();
      chk_state($sformatf("tbl%0d", i), tbl[i].cnt);
      chk($sformatf("tbl%0d.rd_valid", i), 64'(bus.rd_valid), 64'(tbl[i].cnt != 0));
      chk($sformatf("tbl%0d.wr_ready", i), 64'(bus.wr_ready), 64'(tbl[i].cnt != DEPTH));
      if (tbl[i].cnt != 0) begin
        chk($sformatf("tbl%0d.rd_pc", i),   bus.rd_pc, tbl[i].head);
        chk($sformatf("tbl%0d.rd_inst", i), 64'(bus.rd_inst), 64'(inst_of(tbl[i].head)));
      end
    end

    // Concurrent push/pop at count 2, pointers wrap several times
    drive(0, 1, 0, 64'h100); step();
    drive(0, 1, 0, 64'h104); step();
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1, 1, 64'h104 + 64'(4 * k));
      step();
      chk($sformatf("conc%0d.count", k), 64'(bus.count), 64'h2);
      chk($sformatf("conc%0d.rd_pc", k), bus.rd_pc, 64'h100 + 64'(4 * k));
    end
    drive(1, 0, 0, 64'h0); step();
    chk_state("flush_idle", 0);

    // rd_pc4 wraps modulo 2^64
    drive(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC); step();
    chk("wrap.rd_pc",  bus.rd_pc,  64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.rd_pc4", bus.rd_pc4, 64'h0);
    drive(0, 0, 1, 64'h0); step();
    chk_state("wrap_drain", 0);

    // Flush beats a same-cycle push and pop
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 64'h200 + 64'(4 * k)); step();
    end
    chk_state("pre_flush", 3);
    drive(1, 1, 1, 64'h300); step();
    chk_state("flush", 0);
    chk("flush.rd_valid", 64'(bus.rd_valid), 64'h0);
    drive(0, 0, 0, 64'h0); step();
    chk_state("flush_after", 0);

    // Asynchronous reset between edges
    drive(0, 1, 0, 64'h500); step();
    drive(0, 1, 0, 64'h504); step();
    drive(0, 0, 0, 64'h0);
    chk_state("pre_areset", 2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_state("areset", 0);
    chk("areset.rd_valid", 64'(bus.rd_valid), 64'h0);
    chk("areset.rd_pc4",   bus.rd_pc4, 64'h4);
    step();
    reset = 1'b1;

`ifdef INST_BUFFER_BYPASS_EN
    // Same-cycle bypass into an empty buffer
    drive(0, 1, 1, 64'h700);
    #1;
    chk("byp.rd_valid", 64'(bus.rd_valid), 64'h1);
    chk("byp.rd_pc",    bus.rd_pc, 64'h700);
    step();
    chk_state("byp_after", 0);
    drive(0, 0, 0, 64'h0);
`endif

    // Randomized run against a queue model
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic        f, wv, rr, ev;
      logic [63:0] pc, epc;
      int          sz;
      f  = ($urandom_range(15) == 0);
      wv = ($urandom_range(9) < 6);
      rr = ($urandom_range(1) == 1);
      pc = {$urandom(), $urandom()};
      drive(f, wv, rr, pc);
      sz  = q.size();
      ev  = (sz > 0);
      epc = (sz > 0) ? q[0].pc : 64'h0;
`ifdef INST_BUFFER_BYPASS_EN
      if (sz == 0 && wv) begin ev = 1'b1; epc = pc; end
      if (f) ev = 1'b0;
`endif
      @(negedge clk);
      chk($sformatf("rnd%0d.rd_valid", c), 64'(bus.rd_valid), 64'(ev));
      chk($sformatf("rnd%0d.count", c),    64'(bus.count),    64'(sz));
      chk($sformatf("rnd%0d.wr_ready", c), 64'(bus.wr_ready), 64'(sz < DEPTH));
      chk($sformatf("rnd%0d.empty", c),    64'(bus.empty),    64'(sz == 0));
      if (ev) begin
        chk($sformatf("rnd%0d.rd_pc", c),   bus.rd_pc, epc);
        chk($sformatf("rnd%0d.rd_inst", c), 64'(bus.rd_inst), 64'(inst_of(epc)));
        chk($sformatf("rnd%0d.rd_pc4", c),  bus.rd_pc4, epc + 64'd4);
      end
      @(posedge clk);
      if (f) q.delete();
      else begin
`ifdef INST_BUFFER_BYPASS_EN
        if (!(sz == 0 && wv && rr)) begin
`else
        begin
`endif
          if (rr && sz > 0) void'(q.pop_front());
          if (wv && sz < DEPTH) begin
            e.pc = pc; e.inst = inst_of(pc);
            q.push_back(e);
          end
        end
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
